// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display: core status codes, active-low
// 7-segment digit patterns {g,f,e,d,c,b,a} and the displayable minutes ceiling.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } status_e;

  localparam logic [7:0] MAX_MINUTES = 8'd99;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Non-decimal codes blank the digit rather than showing hex glyphs.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Stopwatch core to display link: binary time/status in, multiplexed LED drive out.
interface stopwatch_display_if;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output minutes, seconds, status, input an, seg, dp);
  modport slave  (input minutes, seconds, status, output an, seg, dp);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to two-digit BCD converter, one input bit per clock.
// bin must stay steady for the 8 cycles after load and hold a value below 100.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bin,
  output logic       busy,
  output logic [7:0] bcd
);

  logic [7:0] acc;
  logic [7:0] acc_adj;
  logic [7:0] acc_next;
  logic [2:0] bit_cnt;

  function automatic logic [7:0] add3_nibbles(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] >= 4'd5) r[3:0] = v[3:0] + 4'd3;
    if (v[7:4] >= 4'd5) r[7:4] = v[7:4] + 4'd3;
    return r;
  endfunction

  // MSB first; a hundreds carry cannot occur for inputs below 100.
  always_comb begin
    acc_adj  = add3_nibbles(acc);
    acc_next = 8'({acc_adj, bin[~bit_cnt]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      bcd     <= '0;
    end else if (load) begin
      acc     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      acc     <= acc_next;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        busy <= 1'b0;
        bcd  <= acc_next;
      end
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit mm.ss LED driver; inputs are snapshotted once per scan frame.
// Define STOPWATCH_DISPLAY_BLINK_EN to blink the display while the core is paused.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 4,
  parameter int unsigned BLINK_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst,
  stopwatch_display_if.slave disp
);

  localparam int unsigned      REF_W    = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  // A frame of 4*REFRESH_DIV cycles must cover the 8-cycle BCD conversion.
  if (REFRESH_DIV < 3 || BLINK_FRAMES < 1) begin : g_param_check
    $error("stopwatch_display: needs REFRESH_DIV >= 3 and BLINK_FRAMES >= 1");
  end

  logic [REF_W-1:0] ref_cnt;
  logic [1:0]       dig_idx;
  logic             slot_end;
  logic             frame_end;
  logic [7:0]       snap_min_p0;
  logic [5:0]       snap_sec_p0;
  logic [7:0]       min_bcd;
  logic [7:0]       sec_bcd;
  logic             min_busy;
  logic             sec_busy;
  logic [7:0]       disp_min_p1;
  logic [7:0]       disp_sec_p1;
  logic [3:0]       cur_digit;
  logic             blank;

  function automatic logic [7:0] sat_minutes(input logic [7:0] m);
    return (m > MAX_MINUTES) ? MAX_MINUTES : m;
  endfunction

  assign slot_end  = (ref_cnt == REF_LAST);
  assign frame_end = slot_end && (dig_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      dig_idx <= '0;
    end else if (slot_end) begin
      ref_cnt <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // ---- stage p0: frame-boundary snapshot of the core time ----
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_min_p0 <= '0;
      snap_sec_p0 <= '0;
    end else if (frame_end) begin
      snap_min_p0 <= sat_minutes(disp.minutes);
      snap_sec_p0 <= disp.seconds;
    end
  end

  // Converters start on the capture edge and read the snapshot from the next cycle.
  bin2bcd_seq u_min_bcd (
    .clk  (clk),
    .rst  (rst),
    .load (frame_end),
    .bin  (snap_min_p0),
    .busy (min_busy),
    .bcd  (min_bcd)
  );

  bin2bcd_seq u_sec_bcd (
    .clk  (clk),
    .rst  (rst),
    .load (frame_end),
    .bin  ({2'b00, snap_sec_p0}),
    .busy (sec_busy),
    .bcd  (sec_bcd)
  );

  // ---- stage p1: displayed BCD, swapped only at frame starts ----
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_min_p1 <= '0;
      disp_sec_p1 <= '0;
    end else if (frame_end && !min_busy && !sec_busy) begin
      disp_min_p1 <= min_bcd;
      disp_sec_p1 <= sec_bcd;
    end
  end

  always_comb begin
    cur_digit = disp_sec_p1[3:0];
    case (dig_idx)
      2'd0:    cur_digit = disp_sec_p1[3:0];
      2'd1:    cur_digit = disp_sec_p1[7:4];
      2'd2:    cur_digit = disp_min_p1[3:0];
      default: cur_digit = disp_min_p1[7:4];
    endcase
  end

`ifdef STOPWATCH_DISPLAY_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [1:0]       snap_status_p0;
  logic [BLK_W-1:0] frame_cnt;
  logic             blink_off;

  // Blink follows the status captured with the digits now being loaded, so both share one latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_status_p0 <= ST_IDLE;
      frame_cnt      <= '0;
      blink_off      <= 1'b0;
    end else if (frame_end) begin
      snap_status_p0 <= disp.status;
      if (snap_status_p0 != ST_PAUSE) begin
        frame_cnt <= '0;
        blink_off <= 1'b0;
      end else if (frame_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + BLK_W'(1);
      end
    end
  end

  assign blank = blink_off;
`else
  assign blank = 1'b0;
`endif

  // ---- stage p2: registered LED drive for the current digit slot ----
  always_ff @(posedge clk) begin
    if (rst) begin
      disp.an  <= 4'hF;
      disp.seg <= SEG_OFF;
      disp.dp  <= 1'b1;
    end else begin
      disp.seg <= seg_decode(cur_digit);
      if (blank) begin
        disp.an <= 4'hF;
        disp.dp <= 1'b1;
      end else begin
        disp.an <= ~(4'b0001 << dig_idx);
        disp.dp <= (dig_idx != 2'd2);
      end
    end
  end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter REFRESH_DIV, default 4, SHALL set the clock cycles per digit slot; legal range is 3 or more.
REQ-003 Parameter BLINK_FRAMES, default 4, SHALL set the scan frames per blink half-period.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 minutes  input  8  binary minutes from the stopwatch core, 0..255.
REQ-007 seconds  input  6  binary seconds from the stopwatch core, 0..59.
REQ-008 status  input  2  core state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 reserved (treated as IDLE).
REQ-009 an  output  4  digit enables, active-low, one-hot-zero while scanning.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; each wrap SHALL advance the 2-bit digit index 0->1->2->3->0.
REQ-013 Digit mapping SHALL be:
- index 0 = seconds ones, on an[0]
- index 1 = seconds tens, on an[1]
- index 2 = minutes ones, on an[2]
- index 3 = minutes tens, on an[3]
REQ-014 The 3->0 index advance is a frame boundary; on that cycle minutes, seconds and status SHALL be captured into snapshot registers.
REQ-015 Minutes greater than 99 SHALL be saturated to 99 at capture.
REQ-016 Captured values SHALL be converted to BCD by iterative shift-add-3.
- One bit per cycle.
- Both fields are converted in parallel.
- Conversion completes 8 cycles after capture.
REQ-017 Converted BCD SHALL load the display registers only at the next frame boundary, so displayed values change only at frame starts.
- Capture-to-display latency is exactly one frame (4*REFRESH_DIV cycles).
REQ-018 an, seg and dp SHALL be registered and SHALL reflect the current digit index one cycle after it changes.
REQ-019 Leading zeros SHALL be displayed (no blanking).
REQ-020 dp SHALL be 0 only while index 2 is active, giving an mm.ss separator.
REQ-021 seg SHALL use the standard hex-free 0..9 decode (0 = 7'b1000000); BCD codes 10..15 SHALL drive all segments off.
REQ-022 Input changes between frame boundaries SHALL have no effect on outputs.
REQ-023 A capture while a conversion is still in progress SHALL restart the conversion with the new snapshot.

Reset
REQ-024 On rst=1 the block SHALL drive an=4'hF, seg=7'h7F, dp=1, refresh counter 0, digit index 0, snapshots and display BCD 0, and blink state 0.
REQ-025 The first clock edge after rst falls SHALL produce an=4'b1110, seg=7'b1000000 (displaying 00.00).
REQ-026 Reset asserted mid-frame or mid-conversion SHALL abort the frame or conversion and take effect on that edge.

Configuration
REQ-027 Macro STOPWATCH_DISPLAY_BLINK_EN SHALL control blinking while paused.
- Defined: a frame counter toggles a blink phase every BLINK_FRAMES frames while the captured status is PAUSED. In the off phase an=4'hF and dp=1. Blink phase resets to on whenever the captured status is not PAUSED.
- Undefined: status is ignored, no frame counter is synthesised, and the display never blanks.

Structure
REQ-028 A shared package stopwatch_pkg SHALL hold:
- the status encodings (ST_IDLE, ST_RUN, ST_PAUSE);
- the 7-segment digit constants;
- the MAX_MINUTES=99 constant.
REQ-029 BCD conversion SHALL be a sub-module bin2bcd_seq with ports clk, rst, load, bin[7:0], busy, bcd[7:0], instantiated twice (the seconds instance zero-extended).

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset then release with minutes=0, seconds=0 -> an cycles 1110,1101,1011,0111 every REFRESH_DIV cycles; seg=1000000 on every digit; dp=0 only on 1011.
- minutes=12, seconds=34 held two frames -> second full frame shows digits 4,3,2,1 on an[0..3] (seg 0011001, 0110000, 0100100, 1111001).
- seconds changed 34->35 mid-frame -> no output change until one full frame after the next boundary.
- minutes=150 -> displayed minutes 99.
- Blink enabled, status=PAUSED -> an=1111 for BLINK_FRAMES frames, then resumes scanning; blink disabled -> continuous scanning.
- rst pulsed mid-conversion -> outputs all off on that edge, then display restarts at 00.00.
